fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fq_storage.sv | 32 +++
 rtl/fetch_queue.sv | 109 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and sizing constants for the fetch queue and its storage array.
// Entries carry the instruction word together with its byte address.
package fetch_pkg;

    localparam int INSTR_W    = 32;
    localparam int PACK_SLOTS = 4;
    localparam int DEQ_MAX    = 2;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Entry array for the fetch queue: one write port per pack slot, two
// combinational read ports for the oldest and second-oldest entries.
module fq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic [PACK_SLOTS-1:0]            wr_en,
    input  logic [PACK_SLOTS-1:0][AW-1:0]    wr_addr,
    input  fq_entry_t [PACK_SLOTS-1:0]       wr_data,
    input  logic [DEQ_MAX-1:0][AW-1:0]       rd_addr,
    output fq_entry_t [DEQ_MAX-1:0]          rd_data
);

    fq_entry_t mem [DEPTH];

    // Write addresses within one pack are always distinct, so port order is irrelevant.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PACK_SLOTS; k++) begin
            if (wr_en[k]) begin
                mem[wr_addr[k]] <= wr_data[k];
            end
        end
    end

    for (genvar d = 0; d < DEQ_MAX; d++) begin : g_rd
        assign rd_data[d] = mem[rd_addr[d]];
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between instruction fetch and decode: accepts packs of up to four
// instructions, presents two per cycle. Optional same-cycle bypass: FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_pc,
    input  logic [127:0]              in_pack,
    input  logic [2:0]                in_cnt,
    output logic                      out0_valid,
    output logic                      out1_valid,
    output logic [INSTR_W-1:0]        out0_instr,
    output logic [INSTR_W-1:0]        out1_instr,
    output logic [31:0]               out0_pc,
    output logic [31:0]               out1_pc,
    input  logic [1:0]                deq_cnt,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [AW-1:0] head, tail;
    logic          accept, byp;
    logic [2:0]    pack_cnt, skip, wr_num;
    logic [1:0]    n_vis, deq, deq_store;

    logic [PACK_SLOTS-1:0]         wr_en;
    logic [PACK_SLOTS-1:0][AW-1:0] wr_addr;
    fq_entry_t [PACK_SLOTS-1:0]    wr_data;
    logic [DEQ_MAX-1:0][AW-1:0]    rd_addr;
    fq_entry_t [DEQ_MAX-1:0]       rd_data;

    assign in_ready = !flush && (occupancy <= OW'(DEPTH - PACK_SLOTS));
    assign accept   = in_valid && in_ready;
    assign pack_cnt = (in_cnt >= 3'd1 && in_cnt <= 3'd4) ? in_cnt : 3'd0;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = (occupancy == '0) && !flush && in_valid;
`else
    assign byp = 1'b0;
`endif

    assign rd_addr[0] = head;
    assign rd_addr[1] = head + AW'(1);

    // Instructions taken straight from a bypassed pack are skipped when writing it.
    always_comb begin
        out0_valid = 1'b0;
        out1_valid = 1'b0;
        out0_pc    = rd_data[0].pc;
        out0_instr = rd_data[0].instr;
        out1_pc    = rd_data[1].pc;
        out1_instr = rd_data[1].instr;
        if (byp) begin
            out0_valid = (pack_cnt >= 3'd1);
            out1_valid = (pack_cnt >= 3'd2);
            out0_pc    = in_pc;
            out0_instr = in_pack[127:96];
            out1_pc    = in_pc + 32'd4;
            out1_instr = in_pack[95:64];
        end else if (!flush) begin
            out0_valid = (occupancy >= OW'(1));
            out1_valid = (occupancy >= OW'(2));
        end
        n_vis     = {1'b0, out0_valid} + {1'b0, out1_valid};
        deq       = (deq_cnt > n_vis) ? n_vis : deq_cnt;
        deq_store = byp ? 2'd0 : deq;
        skip      = byp ? {1'b0, deq} : 3'd0;
        wr_num    = accept ? (pack_cnt - skip) : 3'd0;
    end

    always_comb begin
        for (int k = 0; k < PACK_SLOTS; k++) begin
            wr_en[k]         = accept && resetn && (3'(k) >= skip) && (3'(k) < pack_cnt);
            wr_addr[k]       = tail + AW'(3'(k) - skip);
            wr_data[k].pc    = in_pc + 32'(4 * k);
            wr_data[k].instr = in_pack[127 - 32 * k -: 32];
        end
    end

    fq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            head      <= head + AW'(deq_store);
            tail      <= tail + AW'(wr_num);
            occupancy <= occupancy + OW'(wr_num) - OW'(deq_store);
        end
    end

endmodule
